ps2_mouse_device_tx: RTL and testbench

//   Device-side PS/2 mouse emulator transmitter. It generates the PS/2 clock and sends

---
 rtl/ps2_mouse_device_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_mouse_device_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_device_tx.sv
// PS/2 mouse device-side transmitter: clocks 3-byte movement packets to a host.
// Ports: CLOCK/RESET_N, send+btn/dx/dy request, ready/done/aborted, open-drain PS/2 lines.
module ps2_mouse_device_tx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PS2_HZ    = 12_500,
  parameter int IDLE_HOLD = 2500
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       send,
  input  logic [2:0] btn,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  output logic       ready,
  output logic       done,
  output logic       aborted,
  input  logic       ps2ck_i,
  input  logic       ps2dt_i,
  output logic       ps2ck_low,
  output logic       ps2dt_low
);

  localparam int H  = CLK_HZ / (2 * PS2_HZ);
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int IW = $clog2(IDLE_HOLD + 1);

  localparam logic [HW-1:0] HLAST = HW'(H - 1);
  localparam logic [IW-1:0] ILAST = IW'(IDLE_HOLD - 1);
  // Our own clock release needs two cycles to reach ck_s.
  localparam logic [HW-1:0] HSYNC = HW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_END,
    S_ABORT
  } state_t;

  state_t         state;
  logic           ck_m;
  logic           ck_s;
  logic           dt_m;
  logic           dt_s;
  logic [23:0]    pkt;
  logic [1:0]     byte_idx;
  logic [3:0]     bit_idx;
  logic [10:0]    frame;
  logic [HW-1:0]  hcnt;
  logic [IW-1:0]  icnt;
  logic [7:0]     cur;
  logic [10:0]    frame_new;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ck_m <= 1'b1;
      ck_s <= 1'b1;
      dt_m <= 1'b1;
      dt_s <= 1'b1;
    end else begin
      ck_m <= ps2ck_i;
      ck_s <= ck_m;
      dt_m <= ps2dt_i;
      dt_s <= dt_m;
    end
  end

  always_comb begin
    cur = pkt[7:0];
    unique case (byte_idx)
      2'd1:    cur = pkt[15:8];
      2'd2:    cur = pkt[23:16];
      default: cur = pkt[7:0];
    endcase
  end

  // stop, odd parity, data LSB first, start
  always_comb begin
    frame_new = {1'b1, ~^cur, cur, 1'b0};
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      aborted   <= 1'b0;
      ps2ck_low <= 1'b0;
      ps2dt_low <= 1'b0;
      pkt       <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      hcnt      <= '0;
      icnt      <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (send) begin
            pkt      <= {dy[7:0], dx[7:0],
                         2'b00, dy[8], dx[8], 1'b1, btn};
            byte_idx <= '0;
            icnt     <= '0;
            ready    <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          ps2ck_low <= 1'b0;
          ps2dt_low <= 1'b0;
          if (ck_s && dt_s) begin
            if (icnt == ILAST) begin
              frame     <= frame_new;
              bit_idx   <= '0;
              hcnt      <= '0;
              ps2dt_low <= ~frame_new[0];
              state     <= S_HIGH;
            end else begin
              icnt <= icnt + 1'b1;
            end
          end else begin
            icnt <= '0;
          end
        end
        S_HIGH: begin
          // Inhibit on bit 0 is left to WAIT_BUS semantics.
          if (!ck_s && (bit_idx != 4'd0) && (hcnt >= HSYNC)) begin
            ps2dt_low <= 1'b0;
            state     <= S_ABORT;
          end else if (hcnt == HLAST) begin
            hcnt      <= '0;
            ps2ck_low <= 1'b1;
            state     <= S_LOW;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_LOW: begin
          if (hcnt == HLAST) begin
            hcnt      <= '0;
            ps2ck_low <= 1'b0;
            if (bit_idx == 4'd10) begin
              ps2dt_low <= 1'b0;
              state     <= S_END;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              frame     <= {1'b1, frame[10:1]};
              ps2dt_low <= ~frame[1];
              state     <= S_HIGH;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_END: begin
          if (byte_idx == 2'd2) begin
            done  <= 1'b1;
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            icnt     <= '0;
            state    <= S_WAIT;
          end
        end
        S_ABORT: begin
          ps2ck_low <= 1'b0;
          ps2dt_low <= 1'b0;
          aborted   <= 1'b1;
          byte_idx  <= '0;
          icnt      <= '0;
          state     <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_device_tx.sv
// Bench for ps2_mouse_device_tx: pull-up host model decodes frames on clock falls.
// Random and directed packets are checked against a packet-level model.
module tb_ps2_mouse_device_tx;

  localparam int H  = 5;
  localparam int IH = 8;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       send = 1'b0;
  logic [2:0] btn = '0;
  logic [8:0] dx = '0;
  logic [8:0] dy = '0;
  logic       ready;
  logic       done;
  logic       aborted;
  logic       ps2ck_low;
  logic       ps2dt_low;
  logic       host_ck_low = 1'b0;
  logic       host_dt_low = 1'b0;
  logic       ck_line;
  logic       dt_line;

  assign ck_line = !(ps2ck_low || host_ck_low);
  assign dt_line = !(ps2dt_low || host_dt_low);

  ps2_mouse_device_tx #(
    .CLK_HZ(1000),
    .PS2_HZ(100),
    .IDLE_HOLD(IH)
  ) dut (
    .CLOCK(CLOCK),
    .RESET_N(RESET_N),
    .send(send),
    .btn(btn),
    .dx(dx),
    .dy(dy),
    .ready(ready),
    .done(done),
    .aborted(aborted),
    .ps2ck_i(ck_line),
    .ps2dt_i(dt_line),
    .ps2ck_low(ps2ck_low),
    .ps2dt_low(ps2dt_low)
  );

  always #5 CLOCK = ~CLOCK;

  int npass = 0;
  int ntot = 0;

  task automatic chk(input string name, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, got, got, exp, exp);
  endtask

  function automatic logic [7:0] mk(input int k, input logic [2:0] b,
                                    input logic [8:0] x, input logic [8:0] y);
    int sx;
    int sy;
    int v;
    sx = (int'(x) >= 256) ? int'(x) - 512 : int'(x);
    sy = (int'(y) >= 256) ? int'(y) - 512 : int'(y);
    if (k == 0) v = 8 + int'(b) + ((sx < 0) ? 16 : 0) + ((sy < 0) ? 32 : 0);
    else if (k == 1) v = sx & 255;
    else v = sy & 255;
    return 8'(v);
  endfunction

  int         cyc = 0;
  always @(posedge CLOCK) cyc++;

  logic [7:0] exp_pkt [3];
  logic [7:0] rx_q [$];
  logic       busy = 1'b0;
  int         got_n = 0;
  int         bitn = 0;
  logic [10:0] fr = '0;
  logic       prev_ck = 1'b1;
  logic       prev_dt = 1'b1;
  logic       dev_low = 1'b0;
  int         last_fall = 0;
  int         dt_chg = 0;
  int         done_cnt = 0;
  int         abort_cnt = 0;
  logic       inh_arm = 1'b0;
  int         inh_left = 0;
  logic       meas_rel = 1'b0;
  int         rel_cyc = 0;

  always @(negedge CLOCK) begin
    logic cur_ck;
    logic cur_dt;
    logic [7:0] d;
    cur_ck = ck_line;
    cur_dt = dt_line;
    if (!RESET_N) begin
      bitn = 0;
      got_n = 0;
      busy = 1'b0;
      dev_low = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_while_busy", int'(busy), 1);
        chk("done_bytes", got_n, 3);
        chk("done_latency", int'((cyc - last_fall) >= H &&
                                 (cyc - last_fall) <= H + 3), 1);
        busy = 1'b0;
      end
      chk("ready", int'(ready), int'(!busy));
      if (aborted) begin
        abort_cnt++;
        chk("abort_release", int'({ps2ck_low, ps2dt_low}), 0);
        chk("abort_while_busy", int'(busy), 1);
        bitn = 0;
        got_n = 0;
      end
      if (cur_dt !== prev_dt) dt_chg = cyc;
      if (prev_ck && !cur_ck && !host_ck_low) begin
        chk("data_setup", int'((cyc - dt_chg) >= H), 1);
        if (bitn > 0) chk("bit_period", cyc - last_fall, 2 * H);
        if (meas_rel) begin
          chk("lead_in", int'((cyc - rel_cyc) >= IH + H), 1);
          meas_rel = 1'b0;
        end
        fr[bitn] = cur_dt;
        bitn++;
        last_fall = cyc;
        dev_low = 1'b1;
        if (bitn == 11) begin
          d = fr[8:1];
          chk("start_bit", int'(fr[0]), 0);
          chk("stop_bit", int'(fr[10]), 1);
          chk("odd_parity", int'(^fr[9:1]), 1);
          rx_q.push_back(d);
          if (got_n < 3) chk($sformatf("byte%0d", got_n), int'(d),
                             int'(exp_pkt[got_n]));
          else chk("extra_byte", got_n, 2);
          got_n++;
          bitn = 0;
        end
      end
      if (inh_left > 0) begin
        inh_left--;
        if (inh_left == 0) host_ck_low = 1'b0;
      end
      if (!prev_ck && cur_ck) begin
        if (dev_low) chk("clock_low_width", cyc - last_fall, H);
        dev_low = 1'b0;
        if (inh_arm && got_n == 1 && bitn == 4) begin
          host_ck_low = 1'b1;
          inh_arm = 1'b0;
          inh_left = 30;
        end
      end
    end
    prev_ck = cur_ck;
    prev_dt = cur_dt;
  end

  task automatic send_pkt(input logic [2:0] b, input logic [8:0] x,
                          input logic [8:0] y);
    @(posedge CLOCK);
    #2;
    chk("ready_before_send", int'(ready), 1);
    btn = b;
    dx = x;
    dy = y;
    send = 1'b1;
    @(posedge CLOCK);
    for (int k = 0; k < 3; k++) exp_pkt[k] = mk(k, b, x, y);
    busy = 1'b1;
    got_n = 0;
    #2;
    send = 1'b0;
    btn = 3'($urandom);
    dx = 9'($urandom);
    dy = 9'($urandom);
  endtask

  task automatic wait_idle(input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(posedge CLOCK);
      if (!busy) break;
    end
    if (i >= lim) chk("idle_timeout", 0, 1);
    repeat (3) @(posedge CLOCK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int a0;
    int r0;
    repeat (3) @(posedge CLOCK);
    #2;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_ck_low", int'(ps2ck_low), 0);
    chk("rst_dt_low", int'(ps2dt_low), 0);
    RESET_N = 1'b1;
    repeat (5) @(posedge CLOCK);

    // Literal packet: left button, dx=+5, dy=-3.
    d0 = done_cnt;
    r0 = rx_q.size();
    send_pkt(3'b001, 9'd5, 9'h1FD);
    chk("model_b0", int'(exp_pkt[0]), 'h29);
    chk("model_b1", int'(exp_pkt[1]), 'h05);
    chk("model_b2", int'(exp_pkt[2]), 'hFD);
    wait_idle(2000);
    chk("lit_count", rx_q.size() - r0, 3);
    if (rx_q.size() - r0 == 3) begin
      chk("lit_b0", int'(rx_q[r0]), 'h29);
      chk("lit_b1", int'(rx_q[r0 + 1]), 'h05);
      chk("lit_b2", int'(rx_q[r0 + 2]), 'hFD);
    end
    chk("lit_done_once", done_cnt - d0, 1);

    // Host holds clock before the request, releases later.
    @(posedge CLOCK);
    #2 host_ck_low = 1'b1;
    send_pkt(3'($urandom), 9'($urandom), 9'($urandom));
    repeat (40) @(posedge CLOCK);
    #2;
    host_ck_low = 1'b0;
    rel_cyc = cyc;
    meas_rel = 1'b1;
    wait_idle(2000);
    chk("lead_in_seen", int'(meas_rel), 0);

    // Inhibit during bit 4 of B1: abort and full resend.
    d0 = done_cnt;
    a0 = abort_cnt;
    r0 = rx_q.size();
    inh_arm = 1'b1;
    send_pkt(3'b110, 9'h180, 9'h07F);
    wait_idle(3000);
    chk("inh_armed_used", int'(inh_arm), 0);
    chk("inh_abort_once", abort_cnt - a0, 1);
    chk("inh_done_once", done_cnt - d0, 1);
    chk("inh_bytes_seen", rx_q.size() - r0, 4);

    // Second send while busy is ignored.
    d0 = done_cnt;
    send_pkt(3'b010, 9'h0AA, 9'h155);
    repeat (60) @(posedge CLOCK);
    #2;
    btn = 3'b101;
    dx = 9'h011;
    dy = 9'h022;
    send = 1'b1;
    @(posedge CLOCK);
    #2 send = 1'b0;
    wait_idle(2000);
    chk("busy_send_done_once", done_cnt - d0, 1);
    send_pkt(3'b101, 9'h011, 9'h022);
    wait_idle(2000);
    chk("next_send_done", done_cnt - d0, 2);

    // Random packets.
    for (int n = 0; n < 6; n++) begin
      d0 = done_cnt;
      send_pkt(3'($urandom), 9'($urandom), 9'($urandom));
      wait_idle(2000);
      chk("rand_done", done_cnt - d0, 1);
      repeat ($urandom_range(0, 20)) @(posedge CLOCK);
    end

    // Reset in the middle of B2.
    send_pkt(3'($urandom), 9'($urandom), 9'($urandom));
    begin
      int i;
      for (i = 0; i < 2000; i++) begin
        @(posedge CLOCK);
        if (got_n == 2 && bitn >= 3) break;
      end
      if (i >= 2000) chk("b2_reach_timeout", 0, 1);
    end
    #2 RESET_N = 1'b0;
    @(negedge CLOCK);
    #1;
    chk("mid_rst_ck_low", int'(ps2ck_low), 0);
    chk("mid_rst_dt_low", int'(ps2dt_low), 0);
    chk("mid_rst_ready", int'(ready), 1);
    repeat (2) @(posedge CLOCK);
    #2 RESET_N = 1'b1;
    d0 = done_cnt;
    repeat (200) @(posedge CLOCK);
    chk("mid_rst_no_done", done_cnt - d0, 0);

    d0 = done_cnt;
    send_pkt(3'($urandom), 9'($urandom), 9'($urandom));
    wait_idle(2000);
    chk("post_rst_done", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
